// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing types and helpers for the raster scan generator
//   scale_e      : pixel replication factor latched once per frame
//   region_t     : sync window and total count of one scan axis
//   total_count  : active + front porch + sync + back porch
//   region_map   : sync window boundaries and total from the four widths
//   scale_decode : raw 2-bit scale input to scale_e (3 saturates to 4x)
//   scale_shift  : scale_e to coordinate right-shift amount
package video_timing_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  typedef struct packed {
    int unsigned sync_start;
    int unsigned sync_end;
    int unsigned total;
  } region_t;

  function automatic int unsigned total_count(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Regions run active, front porch, sync, back porch; sync is [sync_start, sync_end).
  function automatic region_t region_map(input int unsigned active, input int unsigned fp,
                                         input int unsigned sync, input int unsigned bp);
    region_t r;
    r.sync_start = active + fp;
    r.sync_end   = active + fp + sync;
    r.total      = total_count(active, fp, sync, bp);
    return r;
  endfunction

  function automatic scale_e scale_decode(input logic [1:0] raw);
    case (raw)
      2'd0:    return SCALE_1X;
      2'd1:    return SCALE_2X;
      default: return SCALE_4X;
    endcase
  endfunction

  function automatic logic [1:0] scale_shift(input scale_e s);
    case (s)
      SCALE_2X: return 2'd1;
      SCALE_4X: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// rtl/video_delay_line.sv - enable-gated shift register used to latency-match sync/active to fetched pixels
//   i_clk   : clock
//   i_rstn  : synchronous active-low reset, clears every stage
//   i_en    : shift strobe; stages hold when low
//   i_data  : value entering stage 0
//   o_data  : value leaving the last stage, DEPTH strobes after entry
module video_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/video_scan_gen.sv
// rtl/video_scan_gen.sv - parametrised raster scan generator with look-ahead framebuffer fetch
//   clk_i, rst_i        : clock, synchronous active-low reset
//   en_i                : pixel tick strobe, all scan state advances only on ticks
//   scale_i             : pixel replication (0=1x, 1=2x, 2/3=4x), latched at frame origin
//   line_cmp_i          : line number that raises line_irq_o at the end of its active part
//   pix_i               : fetched pixel, FETCH_LAT ticks after the fetch was issued
//   fetch_o/_x_o/_y_o   : fetch request and scaled coordinates, one tick after the counters
//   h_sync_o, v_sync_o  : syncs with programmable active level
//   video_en_o, video_o : data enable and pixel, aligned with the syncs
//   frame_start_o       : one-cycle pulse after the origin tick
//   line_irq_o          : one-cycle pulse after the line-compare tick
module video_scan_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIX_BITS  = 1,
  parameter int FETCH_LAT = 2,
  parameter int X_W       = 10,
  parameter int Y_W       = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [1:0]          scale_i,
  input  logic [Y_W-1:0]      line_cmp_i,
  input  logic [PIX_BITS-1:0] pix_i,
  output logic                fetch_o,
  output logic [X_W-1:0]      fetch_x_o,
  output logic [Y_W-1:0]      fetch_y_o,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                video_en_o,
  output logic [PIX_BITS-1:0] video_o,
  output logic                frame_start_o,
  output logic                line_irq_o
);

  localparam region_t H_RGN = region_map(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam region_t V_RGN = region_map(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [X_W-1:0]      r_h_cnt;
  logic [Y_W-1:0]      r_v_cnt;
  scale_e              r_scale;
  logic                r_fetch;
  logic [X_W-1:0]      r_fetch_x;
  logic [Y_W-1:0]      r_fetch_y;
  logic                r_h_sync;
  logic                r_v_sync;
  logic                r_video_en;
  logic [PIX_BITS-1:0] r_video;
  logic                r_frame_start;
  logic                r_line_irq;

  logic                w_h_last;
  logic                w_v_last;
  logic                w_active;
  logic                w_hs_raw;
  logic                w_vs_raw;
  logic                w_origin;
  logic                w_line_hit;
  logic [1:0]          w_shift;
  logic [2:0]          w_dly;

  assign w_h_last   = (r_h_cnt == X_W'(H_RGN.total - 1));
  assign w_v_last   = (r_v_cnt == Y_W'(V_RGN.total - 1));
  assign w_active   = (r_h_cnt < X_W'(H_ACTIVE)) && (r_v_cnt < Y_W'(V_ACTIVE));
  assign w_hs_raw   = (r_h_cnt >= X_W'(H_RGN.sync_start)) && (r_h_cnt < X_W'(H_RGN.sync_end));
  assign w_vs_raw   = (r_v_cnt >= Y_W'(V_RGN.sync_start)) && (r_v_cnt < Y_W'(V_RGN.sync_end));
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
  // A compare value at or beyond V total never equals v_cnt, so it stays silent.
  assign w_line_hit = (r_h_cnt == X_W'(H_ACTIVE)) && (r_v_cnt == line_cmp_i);
  // The origin tick still uses the previous frame's scale; its coordinates are 0 either way.
  assign w_shift    = scale_shift(r_scale);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en_i) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Latching only at the origin keeps a whole frame at one scale, so no tearing.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_scale <= SCALE_1X;
    end else if (en_i && w_origin) begin
      r_scale <= scale_decode(scale_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_fetch   <= 1'b0;
      r_fetch_x <= '0;
      r_fetch_y <= '0;
    end else if (en_i) begin
      r_fetch <= w_active;
      if (w_active) begin
        r_fetch_x <= r_h_cnt >> w_shift;
        r_fetch_y <= r_v_cnt >> w_shift;
      end
    end
  end

  // Pulses are cleared on every clk_i so they stay one cycle wide under a gated en_i.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_frame_start <= 1'b0;
      r_line_irq    <= 1'b0;
    end else begin
      r_frame_start <= en_i && w_origin;
      r_line_irq    <= en_i && w_line_hit;
    end
  end

  // FETCH_LAT stages plus the output register line the syncs up with the returned pixel.
  video_delay_line #(
    .WIDTH(3),
    .DEPTH(FETCH_LAT)
  ) u_delay (
    .i_clk (clk_i),
    .i_rstn(rst_i),
    .i_en  (en_i),
    .i_data({w_hs_raw, w_vs_raw, w_active}),
    .o_data(w_dly)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_h_sync   <= ~HS_POL;
      r_v_sync   <= ~VS_POL;
      r_video_en <= 1'b0;
      r_video    <= '0;
    end else if (en_i) begin
      r_h_sync   <= w_dly[2] ? HS_POL : ~HS_POL;
      r_v_sync   <= w_dly[1] ? VS_POL : ~VS_POL;
      r_video_en <= w_dly[0];
      r_video    <= w_dly[0] ? pix_i : '0;
    end
  end

  assign fetch_o       = r_fetch;
  assign fetch_x_o     = r_fetch_x;
  assign fetch_y_o     = r_fetch_y;
  assign h_sync_o      = r_h_sync;
  assign v_sync_o      = r_v_sync;
  assign video_en_o    = r_video_en;
  assign video_o       = r_video;
  assign frame_start_o = r_frame_start;
  assign line_irq_o    = r_line_irq;

endmodule

// File: doc/video_scan_gen.md
# video_scan_gen

Parametrised raster scan generator for the RISC-V template video path. It is the successor to the fixed 1-bit VGA timing logic behind `v_sync`/`h_sync`/`video_en`/`video`. The block runs H/V counters from a pixel-enable strobe and issues framebuffer fetch coordinates ahead of the beam. It realigns the returned pixel data with sync and enable through a latency-matched pipeline, and adds integer pixel replication, programmable sync polarity and line/frame event pulses for the core.

## Interface

**Parameters**

- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync widths, in pixel ticks.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync widths, in lines.
- `HS_POL`, 0 / `VS_POL`, 0: active level of `h_sync_o` / `v_sync_o`.
- `PIX_BITS`, 1: pixel width. Range 1..24.
- `FETCH_LAT`, 2: pixel ticks from a fetch to valid `pix_i`. Range 1..8.
- `X_W`, 10 / `Y_W`, 10: counter widths. Each must be at least clog2 of the H / V total.

**Ports**

Clock and reset:

- `clk_i` in, 1: single clock. Core clock or pixel clock.
- `rst_i` in, 1: reset. Synchronous, active-low.

Control and pixel input:

- `en_i` in, 1: pixel tick strobe. All state advances only in cycles where `en_i`=1.
- `scale_i` in, 2: pixel replication. 0=1x, 1=2x, 2=4x, 3=treated as 4x.
- `line_cmp_i` in, Y_W: line-compare value for `line_irq_o`.
- `pix_i` in, PIX_BITS: fetched pixel data.

Fetch request outputs:

- `fetch_o` out, 1: fetch request for the current tick.
- `fetch_x_o` out, X_W: fetch column, after scaling.
- `fetch_y_o` out, Y_W: fetch row, after scaling.

Video outputs:

- `h_sync_o` out, 1: horizontal sync.
- `v_sync_o` out, 1: vertical sync.
- `video_en_o` out, 1: data enable.
- `video_o` out, PIX_BITS: pixel out. Forced to 0 outside the active area.

Event pulses:

- `frame_start_o` out, 1: one-cycle pulse at the start of each frame.
- `line_irq_o` out, 1: one-cycle pulse on line-compare match.

## Operation

**Totals**

- H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP.
- V_TOT is formed the same way from the vertical parameters.
- Regions, in order: active, front porch, sync, back porch.

**Counters**

- `h_cnt` runs 0..H_TOT-1 and wraps to 0.
- `v_cnt` increments on each h wrap and wraps 0..V_TOT-1.
- Both counters are held when `en_i`=0.

**Active area and fetch**

- Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Each active tick registers `fetch_o`=1 with fetch_x = h_cnt >> s and fetch_y = v_cnt >> s, where s = 0, 1 or 2 from the scale.
- Outside the active area `fetch_o`=0 and the coordinates hold their last value.

**Scale latch**

- `scale_i` is latched only on the tick where h_cnt=0 and v_cnt=0.
- A mid-frame change takes effect from the next frame, so there is no tearing.

**Sync generation**

- Raw sync is asserted while the counter is inside the H (or V) sync region.
- The output level is `HS_POL` / `VS_POL` when asserted and its inverse otherwise.

**Delay pipeline**

- Raw hs, vs and active pass through a FETCH_LAT-deep delay line clocked by `en_i`.
- After the delay they are registered together with `pix_i` into the output registers.
- `video_o` = `pix_i` when the delayed active bit is 1, otherwise 0.

**Event pulses**

- `frame_start_o`: high for one clk_i cycle following the tick where h_cnt=0 and v_cnt=0, in the counter stage (undelayed).
- `line_irq_o`: high for one clk_i cycle following the tick where h_cnt=H_ACTIVE and v_cnt=`line_cmp_i`.
- If `line_cmp_i` ≥ V_TOT, `line_irq_o` never fires.

**Reset**

- Counters, delay line and scale are cleared to 0.
- `h_sync_o`=~HS_POL and `v_sync_o`=~VS_POL.
- `video_en_o`, `video_o`, `fetch_o`, `fetch_x_o`, `fetch_y_o`, `frame_start_o` and `line_irq_o` are all 0.
- Reset takes priority over `en_i`.
- A reset mid-line restarts the scan at (0,0) on the next tick.
- The first tick after reset produces `frame_start_o`.

## Timing

- Fetch latency: counter state (h,v) at tick t gives `fetch_*` valid from tick t+1.
- Pixel return: `pix_i` is sampled FETCH_LAT ticks after the fetch.
- Output latency: `h_sync_o`, `v_sync_o`, `video_en_o` and `video_o` for (h,v) appear at tick t+FETCH_LAT+1. All four are exactly aligned.
- With `en_i` gated, "tick" counts `en_i` cycles. Outputs are stable between ticks.
- Pulses are one clk_i cycle wide regardless of the `en_i` duty cycle.
- Simultaneous events: when v_cnt=`line_cmp_i`=0, `line_irq_o` still fires at h=H_ACTIVE, independent of `frame_start_o`.

## Structure

- Package `video_timing_pkg` contains:
  - the scale enum (SCALE_1X, SCALE_2X, SCALE_4X);
  - a function computing H_TOT / V_TOT;
  - a function mapping region boundaries from the timing parameters.
- Sub-module `video_delay_line` is an enable-gated shift register with parameters WIDTH and DEPTH. It delays {hs, vs, active}.

## Test plan

- **Reset values:** assert `rst_i`=0 for 3 cycles with `en_i`=1. Require all outputs at their reset values; `h_sync_o`=1 and `v_sync_o`=1 for POL=0.
- **640x480 frame, `en_i`=1 constantly:**
  - line period is 800 ticks, `h_sync_o` is low for 96 ticks, `video_en_o` is high for 640 ticks per line;
  - frame is 525 lines, `v_sync_o` is low for 2 lines;
  - `frame_start_o` occurs every 420000 cycles.
- **Pixel alignment:** FETCH_LAT=2 with a model returning `pix_i` = fetch_x[0] after 2 ticks. Require `video_o` to alternate 0,1,0,1 starting on the first `video_en_o` cycle, with no shift.
- **Scaling:** set `scale_i`=1 mid-frame. Require the current frame to stay 1x. The next frame must give fetch_x 0,0,1,1,… up to 319, and fetch_y repeating each row twice.
- **Line compare and gated enable:** `line_cmp_i`=100 with `en_i` high every 3rd cycle. Require exactly one `line_irq_o` per frame, 1 cycle wide, and a line period of 2400 clk_i cycles.
- **Reset mid-scan:** pulse `rst_i` low during line 200 at h=300. Require outputs at reset values, then `frame_start_o` on the first tick after release.
